// File: rtl/sram_sweep_ctrl_pkg.sv
// Shared memory-test package: sweep FSM state encoding and default bus widths.
package sram_sweep_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 19;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    R_ADDR  = 3'd4,
    R_WAIT  = 3'd5,
    R_CAPT  = 3'd6,
    DONE    = 3'd7
  } sweep_state_e;

  // True for the three states in which the controller owns the data bus.
  function automatic logic is_write_state(input sweep_state_e s);
    return (s == W_SETUP) || (s == W_PULSE) || (s == W_HOLD);
  endfunction

endpackage

// File: rtl/sram_addr_ctr.sv
// Sweep address counter: synchronous clear, saturating increment and a
// terminal-count flag raised when the current address is the last one.
module sram_addr_ctr
  import sram_sweep_ctrl_pkg::*;
#(
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              at_max
);

  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;

  assign addr   = addr_q;
  assign at_max = (addr_q == ADDR_MAX);

  // Clear wins over increment; the increment is suppressed at the last address so it never wraps.
  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (inc && !at_max) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Address register, cleared asynchronously with the rest of the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/sram_sweep_ctrl.sv
// Asynchronous SRAM sweep controller: writes or reads every address from 0 to
// ADDR_MAX with fixed three-cycle word timing and registered strobes.
module sram_sweep_ctrl
  import sram_sweep_ctrl_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rnw,
  input  logic [DATA_W-1:0] wdat,
  output logic              ready,
  output logic              stop,
  output logic [DATA_W-1:0] rdat,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  sweep_state_e      state_d, state_q;
  logic              rnw_d, rnw_q;
  logic              ready_d, ready_q;
  logic              stop_d, stop_q;
  logic [DATA_W-1:0] rdat_d, rdat_q;
  logic              ce_n_d, ce_n_q;
  logic              oe_n_d, oe_n_q;
  logic              we_n_d, we_n_q;
  logic              oe_n_prev_d, oe_n_prev_q;
  logic              addr_clr;
  logic              addr_inc;
  logic              addr_at_max;
  logic              dq_oe;

  sram_addr_ctr #(
    .ADDR_W   (ADDR_W),
    .ADDR_MAX (ADDR_MAX)
  ) u_addr_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (addr_clr),
    .inc    (addr_inc),
    .addr   (SRAM_ADDR),
    .at_max (addr_at_max)
  );

  // The bus is only driven in write states, and never in the cycle right after
  // OE_N was low, so a start that aborts a read into a write cannot contend with the SRAM.
  assign dq_oe   = is_write_state(state_q) && oe_n_prev_q;
  assign SRAM_DQ = dq_oe ? wdat : {DATA_W{1'bz}};

  assign ready     = ready_q;
  assign stop      = stop_q;
  assign rdat      = rdat_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;

  // Next-state logic; strobes and pulses are decoded from the next state so they register in step with it.
  always_comb begin
    state_d     = state_q;
    rnw_d       = rnw_q;
    rdat_d      = rdat_q;
    addr_clr    = 1'b0;
    addr_inc    = 1'b0;
    oe_n_prev_d = oe_n_q;

    if (start) begin
      rnw_d    = rnw;
      addr_clr = 1'b1;
      state_d  = rnw ? R_ADDR : W_SETUP;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        W_SETUP: state_d = W_PULSE;
        W_PULSE: state_d = W_HOLD;
        R_ADDR:  state_d = R_WAIT;
        R_WAIT: begin
          rdat_d  = SRAM_DQ;
          state_d = R_CAPT;
        end
        W_HOLD, R_CAPT: begin
          if (addr_at_max) begin
            addr_clr = 1'b1;
            state_d  = DONE;
          end else begin
            addr_inc = 1'b1;
            state_d  = rnw_q ? R_ADDR : W_SETUP;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    ce_n_d  = (state_d == IDLE) || (state_d == DONE);
    oe_n_d  = !((state_d == R_ADDR) || (state_d == R_WAIT));
    we_n_d  = (state_d != W_PULSE);
    ready_d = (state_d == W_HOLD) || (state_d == R_CAPT);
    stop_d  = (state_d == DONE);
  end

  // FSM state and registered outputs; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnw_q       <= 1'b1;
      ready_q     <= 1'b0;
      stop_q      <= 1'b0;
      rdat_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rnw_q       <= rnw_d;
      ready_q     <= ready_d;
      stop_q      <= stop_d;
      rdat_q      <= rdat_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      oe_n_prev_q <= oe_n_prev_d;
    end
  end

endmodule

// File: tb/tb_sram_sweep_ctrl.sv
// Testbench for sram_sweep_ctrl with a small behavioural SRAM on the bus.
module tb_sram_sweep_ctrl;

  localparam int                DATA_W   = 8;
  localparam int                ADDR_W   = 19;
  localparam int                WORDS    = 4;
  localparam logic [ADDR_W-1:0] ADDR_MAX = 19'(WORDS - 1);

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              rnw   = 1'b0;
  logic [DATA_W-1:0] wdat  = '0;

  wire               ready;
  wire               stop;
  wire  [DATA_W-1:0] rdat;
  wire  [DATA_W-1:0] sramDq;
  wire  [ADDR_W-1:0] sramAddr;
  wire               ceN;
  wire               oeN;
  wire               weN;

  logic [DATA_W-1:0] sramMem [WORDS];
  logic [DATA_W-1:0] refMem  [WORDS];
  logic [DATA_W-1:0] wrData  [WORDS];

  int   compareCount  = 0;
  int   mismatchCount = 0;
  logic monitorOn     = 1'b0;
  logic prevReady     = 1'b0;
  logic prevStop      = 1'b0;
  logic prevOeN       = 1'b1;

  always #5 clk = ~clk;

  sram_sweep_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ADDR_MAX (ADDR_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rnw       (rnw),
    .wdat      (wdat),
    .ready     (ready),
    .stop      (stop),
    .rdat      (rdat),
    .SRAM_DQ   (sramDq),
    .SRAM_ADDR (sramAddr),
    .SRAM_CE_N (ceN),
    .SRAM_OE_N (oeN),
    .SRAM_WE_N (weN)
  );

  // Behavioural SRAM: drives the bus while selected with output enable, stores while write enable is low.
  wire modelDrive = !ceN && !oeN && weN && (sramAddr < 19'(WORDS));
  assign sramDq = modelDrive ? sramMem[sramAddr[1:0]] : {DATA_W{1'bz}};

  always @(negedge clk) begin
    if (rst_n && !ceN && !weN && (sramAddr < 19'(WORDS))) begin
      sramMem[sramAddr[1:0]] <= sramDq;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Bus protocol rules checked every cycle.
  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput("oe_we_overlap", 32'(!oeN && !weN), 32'd0);
      checkOutput("dq_driven_near_oe", 32'(dut.dq_oe && (!oeN || !prevOeN)), 32'd0);
      checkOutput("ready_pulse", 32'(ready && prevReady), 32'd0);
      checkOutput("stop_pulse", 32'(stop && prevStop), 32'd0);
    end
    prevReady = ready;
    prevStop  = stop;
    prevOeN   = oeN;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pulse start for one clock edge; returns at the negedge of the first sweep cycle.
  task automatic applyStimulus(input logic readMode);
    start = 1'b1;
    rnw   = readMode;
    if (!readMode) wdat = wrData[0];
    @(negedge clk);
    start = 1'b0;
    rnw   = 1'($urandom_range(0, 1));
  endtask

  // Start a sweep and check every cycle against the word timetable; stop early at lastCycle if nonzero.
  task automatic runSweep(input logic readMode, input int lastCycle);
    int   k;
    int   p;
    logic inSweep;
    applyStimulus(readMode);
    for (int c = 1; c <= 3 * WORDS + 2; c++) begin
      k       = (c - 1) / 3;
      p       = (c - 1) % 3;
      inSweep = (c <= 3 * WORDS);
      checkOutput("ce_n", 32'(ceN), 32'(!inSweep));
      checkOutput("we_n", 32'(weN), 32'(!(!readMode && inSweep && p == 1)));
      checkOutput("oe_n", 32'(oeN), 32'(!(readMode && inSweep && p < 2)));
      checkOutput("ready", 32'(ready), 32'(inSweep && p == 2));
      checkOutput("stop", 32'(stop), 32'(c == 3 * WORDS + 1));
      checkOutput("addr", 32'(sramAddr), inSweep ? 32'(k) : 32'd0);
      if (readMode && inSweep && p == 2) checkOutput("rdat", 32'(rdat), 32'(refMem[k]));
      if (!readMode && inSweep && p == 1) refMem[k] = wrData[k];
      if (!readMode && inSweep && p == 2 && k + 1 < WORDS) wdat = wrData[k + 1];
      if (c == lastCycle) return;
      @(negedge clk);
    end
  endtask

  task automatic checkMemory();
    for (int i = 0; i < WORDS; i++) checkOutput($sformatf("sram_mem%0d", i), 32'(sramMem[i]), 32'(refMem[i]));
  endtask

  task automatic randomGap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      sramMem[i] = '0;
      refMem[i]  = '0;
    end
    #2 rst_n = 1'b0;
    #10;
    checkOutput("rst_ce_n", 32'(ceN), 32'd1);
    checkOutput("rst_oe_n", 32'(oeN), 32'd1);
    checkOutput("rst_we_n", 32'(weN), 32'd1);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_stop", 32'(stop), 32'd0);
    checkOutput("rst_rdat", 32'(rdat), 32'd0);
    checkOutput("rst_addr", 32'(sramAddr), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    monitorOn = 1'b1;
    repeat (2) @(negedge clk);

    wrData[0] = 8'hA5;
    wrData[1] = 8'h5A;
    wrData[2] = 8'h3C;
    wrData[3] = 8'hC3;
    runSweep(1'b0, 0);
    checkMemory();
    randomGap();
    runSweep(1'b1, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < WORDS; i++) wrData[i] = 8'($urandom);
      randomGap();
      runSweep(1'b0, 0);
      checkMemory();
      randomGap();
      runSweep(1'b1, 0);
    end

    // Abort a write sweep in the write pulse of address 2 with a read sweep.
    for (int i = 0; i < WORDS; i++) wrData[i] = 8'($urandom);
    randomGap();
    runSweep(1'b0, 8);
    runSweep(1'b1, 0);

    // Reset while a read is waiting for data.
    randomGap();
    runSweep(1'b1, 2);
    #1 rst_n = 1'b0;
    monitorOn = 1'b0;
    #1;
    checkOutput("async_ce_n", 32'(ceN), 32'd1);
    checkOutput("async_oe_n", 32'(oeN), 32'd1);
    checkOutput("async_we_n", 32'(weN), 32'd1);
    checkOutput("async_dq_oe", 32'(dut.dq_oe), 32'd0);
    checkOutput("async_rdat", 32'(rdat), 32'd0);
    checkOutput("async_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    monitorOn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_ready", 32'(ready), 32'd0);
      checkOutput("post_rst_stop", 32'(stop), 32'd0);
      checkOutput("post_rst_ce_n", 32'(ceN), 32'd1);
    end
    runSweep(1'b1, 0);
    checkMemory();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/sram_sweep_ctrl.md
SRAM_SWEEP_CTRL -- requirements
Module: sram_sweep_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: SRAM data width.
REQ-002 Parameter ADDR_W, default 19: SRAM address width.
REQ-003 Parameter ADDR_MAX, default {ADDR_W{1'b1}}: last swept address; lowered in simulation.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse; begins a sweep from address 0.
REQ-007 rnw  input  1  sweep direction (1 = read, 0 = write); sampled together with start.
REQ-008 wdat  input  DATA_W  write data for the current word; must stay stable until that word's ready.
REQ-009 ready  output  1  one-cycle pulse, once per completed word.
REQ-010 stop  output  1  one-cycle pulse when the sweep is complete.
REQ-011 rdat  output  DATA_W  registered read data; valid while ready is high in a read sweep.
REQ-012 SRAM_DQ  inout  DATA_W  SRAM data bus.
REQ-013 SRAM_ADDR  output  ADDR_W  SRAM address.
REQ-014 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low SRAM strobes.

Function
REQ-015 States:
- IDLE
- Write path: W_SETUP, W_PULSE, W_HOLD
- Read path: R_ADDR, R_WAIT, R_CAPT
- DONE
REQ-016 start high at edge N, in any state: rnw latched, address set to 0, and from cycle N+1 the FSM is in W_SETUP (rnw=0) or R_ADDR (rnw=1).
REQ-017 A start during a sweep aborts it: no ready or stop for the aborted word.
REQ-018 Write word (3 cycles):
- W_SETUP: CE_N=0, WE_N=1.
- W_PULSE: CE_N=0, WE_N=0.
- W_HOLD: CE_N=0, WE_N=1, ready=1.
- OE_N=1 throughout.
REQ-019 SRAM_DQ is driven combinationally with wdat only in W_SETUP, W_PULSE and W_HOLD; it is high-Z in all other states.
REQ-020 Read word (3 cycles):
- R_ADDR: CE_N=0, OE_N=0.
- R_WAIT: CE_N=0, OE_N=0; rdat captures SRAM_DQ on the edge leaving R_WAIT.
- R_CAPT: CE_N=0, OE_N=1, ready=1.
- WE_N=1 throughout.
REQ-021 Word throughput is exactly 3 cycles for reads and writes; ready is never high on two consecutive cycles.
REQ-022 After W_HOLD or R_CAPT with address < ADDR_MAX: address increments by 1 and the next state is W_SETUP or R_ADDR respectively.
REQ-023 After W_HOLD or R_CAPT with address == ADDR_MAX: next state is DONE.
REQ-024 DONE:
- stop=1 for exactly one cycle;
- all strobes inactive, address returns to 0;
- next state is IDLE.
REQ-025 IDLE: CE_N=OE_N=WE_N=1, DQ high-Z, ready=stop=0, rdat holds its last value.
REQ-026 Address arithmetic is ADDR_W bits wide; it never wraps within a sweep.
REQ-027 Bus turnaround: OE_N and WE_N are never low in the same cycle. DQ is never driven while OE_N=0 in this cycle or the previous cycle.

Reset
REQ-028 rst_n low, asynchronously:
- state=IDLE, address=0, rdat=0, latched rnw=1;
- ready=stop=0;
- CE_N=OE_N=WE_N=1, DQ high-Z.
REQ-029 Reset asserted mid-access forces the strobes inactive immediately, without waiting for a clock edge.

Structure
REQ-030 The state encoding enum and default DATA_W/ADDR_W constants reside in the shared memory-test package.
REQ-031 The address counter (clear, increment, terminal-count flag == ADDR_MAX) is a single sub-module named sram_addr_ctr; everything else is flat.

Verification (ADDR_MAX=3, DATA_W=8, SRAM behavioural model)
REQ-032 Write sweep: start with rnw=0; wdat is 8'hA5/5A/3C/C3, advanced on each ready -> 4 ready pulses 3 cycles apart, model holds A5,5A,3C,C3 at addresses 0..3, one stop pulse in the cycle after the 4th ready.
REQ-033 Read sweep after REQ-032: start with rnw=1 -> ready pulses with rdat = A5,5A,3C,C3 in order, then one stop.
REQ-034 Latency: start at edge N -> CE_N=0 and ADDR=0 in cycle N+1; first ready in cycle N+3.
REQ-035 Abort: start with rnw=1 during W_PULSE of address 2 -> WE_N high next cycle, DQ released, read sweep from address 0, no stop from the aborted write sweep.
REQ-036 Reset mid-R_WAIT -> strobes high and DQ high-Z asynchronously, rdat=0; no ready/stop until the next start.
REQ-037 Assertions over all tests: no cycle with OE_N=0 and WE_N=0; no cycle with DQ driven and OE_N=0; ready and stop are one-cycle pulses.
